// File: rtl/march_bist_pkg.sv
// Shared types, March element tables and small helpers for the March BIST engine.
// The element tables are the only place the MATS+ and March C- algorithms are described.
package march_bist_pkg;

   localparam int ELEM_W = 3;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

   typedef enum logic [1:0] {OP_W0, OP_W1, OP_R0, OP_R1} op_e;

   // dir = 1 walks addresses N-1..0; ops[0] is issued first at each address
   typedef struct packed {
      logic       dir;
      logic [1:0] nops;
      op_e  [1:0] ops;
   } elem_t;

   localparam logic [ELEM_W-1:0] MATS_LAST   = 3'd2;
   localparam logic [ELEM_W-1:0] MARCHC_LAST = 3'd5;

   function automatic elem_t mk_elem(input logic dir, input logic [1:0] nops,
                                     input op_e first, input op_e second);
      elem_t e;
      e.dir    = dir;
      e.nops   = nops;
      e.ops[0] = first;
      e.ops[1] = second;
      return e;
   endfunction

   localparam elem_t MATS_TBL [3] = '{
      mk_elem(1'b0, 2'd1, OP_W0, OP_W0),
      mk_elem(1'b0, 2'd2, OP_R0, OP_W1),
      mk_elem(1'b1, 2'd2, OP_R1, OP_W0)
   };

   localparam elem_t MARCHC_TBL [6] = '{
      mk_elem(1'b0, 2'd1, OP_W0, OP_W0),
      mk_elem(1'b0, 2'd2, OP_R0, OP_W1),
      mk_elem(1'b0, 2'd2, OP_R1, OP_W0),
      mk_elem(1'b1, 2'd2, OP_R0, OP_W1),
      mk_elem(1'b1, 2'd2, OP_R1, OP_W0),
      mk_elem(1'b0, 2'd1, OP_R0, OP_R0)
   };

   function automatic logic elem_dir(input logic alg, input logic [ELEM_W-1:0] idx);
      elem_dir = 1'b0;
      if (alg) begin
         if (idx <= MARCHC_LAST) elem_dir = MARCHC_TBL[idx].dir;
      end else if (idx <= MATS_LAST) begin
         elem_dir = MATS_TBL[idx[1:0]].dir;
      end
   endfunction

   function automatic logic [1:0] elem_nops(input logic alg, input logic [ELEM_W-1:0] idx);
      elem_nops = 2'd1;
      if (alg) begin
         if (idx <= MARCHC_LAST) elem_nops = MARCHC_TBL[idx].nops;
      end else if (idx <= MATS_LAST) begin
         elem_nops = MATS_TBL[idx[1:0]].nops;
      end
   endfunction

   function automatic op_e elem_op(input logic alg, input logic [ELEM_W-1:0] idx, input logic sel);
      elem_op = OP_W0;
      if (alg) begin
         if (idx <= MARCHC_LAST) elem_op = MARCHC_TBL[idx].ops[sel];
      end else if (idx <= MATS_LAST) begin
         elem_op = MATS_TBL[idx[1:0]].ops[sel];
      end
   endfunction

   function automatic logic op_is_write(input op_e op);
      return (op == OP_W0) || (op == OP_W1);
   endfunction

   // "1" ops use the inverted background
   function automatic logic op_is_inv(input op_e op);
      return (op == OP_W1) || (op == OP_R1);
   endfunction

   function automatic logic [63:0] checker_word();
      return {32{2'b01}};
   endfunction

endpackage

// File: rtl/march_bist_cmp.sv
// Read-tag delay line and comparator: lines each read's expected word up with the
// returning memory data, counts miscompares and latches the first failing access.
module march_bist_cmp
   import march_bist_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4,
   parameter int RD_LAT = 3,
   parameter int ERR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              rd_vld,
   input  logic [DATA_W-1:0] rd_exp,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [ELEM_W-1:0] rd_elem,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [ELEM_W-1:0] fail_elem,
   output logic [DATA_W-1:0] fail_exp,
   output logic [DATA_W-1:0] fail_act
);

   typedef struct packed {
      logic              vld;
      logic [DATA_W-1:0] exp;
      logic [ADDR_W-1:0] addr;
      logic [ELEM_W-1:0] elem;
   } tag_t;

   tag_t pipe [RD_LAT];
   tag_t tail;
   logic miss;

   // Stage 0 is loaded on the issue edge, so the tail meets the data RD_LAT edges later
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= '{rd_vld, rd_exp, rd_addr, rd_elem};
         for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign tail = pipe[RD_LAT-1];
   assign miss = tail.vld && (tail.exp != mem_rdata);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         err_cnt   <= '0;
         fail_addr <= '0;
         fail_elem <= '0;
         fail_exp  <= '0;
         fail_act  <= '0;
      end else if (miss) begin
         if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
         if (err_cnt == '0) begin
            fail_addr <= tail.addr;
            fail_elem <= tail.elem;
            fail_exp  <= tail.exp;
            fail_act  <= mem_rdata;
         end
      end
   end

endmodule

// File: rtl/march_bist_engine.sv
// March BIST sequencer: walks the selected element table over the RAM one op per cycle,
// then drains the read pipeline before reporting done/pass.
module march_bist_engine
   import march_bist_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 4,
   parameter int RD_LAT = 3,
   parameter int ERR_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              alg_sel,
   input  logic              bg_sel,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [2:0]        fail_elem,
   output logic [DATA_W-1:0] fail_exp,
   output logic [DATA_W-1:0] fail_act,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [63:0]       CB_FULL    = checker_word();
   localparam logic [DATA_W-1:0] BG_CB      = CB_FULL[DATA_W-1:0];
   localparam logic [2:0]        DRAIN_LAST = 3'(RD_LAT);

   state_e              state;
   logic                alg;
   logic [DATA_W-1:0]   bg;
   logic [ELEM_W-1:0]   elem;
   logic                op_idx;
   logic [ADDR_W-1:0]   addr;
   logic [DATA_W-1:0]   op_data;
   logic [2:0]          drain_cnt;

   logic                cur_dir, n_dir;
   logic                op_last, addr_end, run_last, start_acc;
   logic [ELEM_W-1:0]   n_elem;
   logic                n_op;
   logic [ADDR_W-1:0]   n_addr;
   op_e                 n_code;

   // The counters name the op currently on the bus; this works out the one after it
   always_comb begin
      cur_dir  = elem_dir(alg, elem);
      op_last  = (elem_nops(alg, elem) == 2'd1) || op_idx;
      addr_end = cur_dir ? (addr == '0) : (addr == '1);
      run_last = op_last && addr_end && (elem == (alg ? MARCHC_LAST : MATS_LAST));
      n_elem   = elem;
      n_op     = 1'b0;
      n_addr   = addr;
      if (!op_last) n_op = 1'b1;
      else if (!addr_end) n_addr = cur_dir ? addr - 1'b1 : addr + 1'b1;
      else n_elem = elem + 3'd1;
      n_dir = elem_dir(alg, n_elem);
      if (op_last && addr_end) n_addr = n_dir ? '1 : '0;
      n_code = elem_op(alg, n_elem, n_op);
   end

   assign start_acc = start && ((state == ST_IDLE) || (state == ST_DONE));

   // Start edge already presents the first op (w0 at address 0, common to both algorithms)
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         alg       <= 1'b0;
         bg        <= '0;
         elem      <= '0;
         op_idx    <= 1'b0;
         addr      <= '0;
         op_data   <= '0;
         drain_cnt <= '0;
         mem_we    <= 1'b0;
         mem_re    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state   <= ST_RUN;
                  alg     <= alg_sel;
                  bg      <= bg_sel ? BG_CB : '0;
                  op_data <= bg_sel ? BG_CB : '0;
                  elem    <= '0;
                  op_idx  <= 1'b0;
                  addr    <= '0;
                  mem_we  <= 1'b1;
                  mem_re  <= 1'b0;
                  busy    <= 1'b1;
                  done    <= 1'b0;
                  pass    <= 1'b0;
               end
            end
            ST_RUN: begin
               if (run_last) begin
                  state     <= ST_DRAIN;
                  mem_we    <= 1'b0;
                  mem_re    <= 1'b0;
                  drain_cnt <= '0;
               end else begin
                  elem    <= n_elem;
                  op_idx  <= n_op;
                  addr    <= n_addr;
                  mem_we  <= op_is_write(n_code);
                  mem_re  <= !op_is_write(n_code);
                  op_data <= op_is_inv(n_code) ? ~bg : bg;
               end
            end
            ST_DRAIN: begin
               if (drain_cnt == DRAIN_LAST) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_cnt == '0);
               end else begin
                  drain_cnt <= drain_cnt + 3'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign mem_addr  = addr;
   assign mem_wdata = op_data;

   march_bist_cmp #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT),
      .ERR_W  (ERR_W)
   ) u_cmp (
      .clk       (clk),
      .rst       (rst),
      .clr       (start_acc),
      .rd_vld    (mem_re),
      .rd_exp    (op_data),
      .rd_addr   (addr),
      .rd_elem   (elem),
      .mem_rdata (mem_rdata),
      .err_cnt   (err_cnt),
      .fail_addr (fail_addr),
      .fail_elem (fail_elem),
      .fail_exp  (fail_exp),
      .fail_act  (fail_act)
   );

endmodule
